// File: rtl/matrix_pkg.sv
// Shared constants and FSM state type for the matrix loader.
package matrix_pkg;

    localparam int DATA_W     = 8;
    localparam int N          = 5;
    localparam int NUM_ELEM   = N * N;
    localparam int ELEM_IDX_W = $clog2(NUM_ELEM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/matrix_loader.sv
// Collects N*N streamed elements (row-major) into a parallel matrix for the inverter.
// Optional pivot-zero flag enabled by macro MATRIX_LOADER_PIVOT_CHECK_EN.
module matrix_loader #(
    parameter int DATA_W = matrix_pkg::DATA_W,
    parameter int N      = matrix_pkg::N
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [N*N*DATA_W-1:0]    mat_data,
    output logic                     mat_valid,
    input  logic                     mat_ack,
    output logic                     frame_err,
    output logic                     pivot_zero,
    output logic [7:0]               mat_cnt
);
    import matrix_pkg::*;

    localparam int ELEMS = N * N;
    localparam int IW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    state_e                  state_r;
    state_e                  state_s;
    logic [IW-1:0]           elem_idx_r;
    logic [IW-1:0]           elem_idx_s;
    logic                    xfer_s;
    logic                    err_s;
    logic                    ack_s;
    logic                    in_ready_r;
    logic                    mat_valid_r;
    logic                    frame_err_r;
    logic [7:0]              mat_cnt_r;
    logic [ELEMS*DATA_W-1:0] mat_data_r;

    assign xfer_s = in_valid && in_ready_r;

    // Next-state and framing check; a frame must end with in_last exactly on the final slot.
    always_comb begin
        state_s    = state_r;
        elem_idx_s = elem_idx_r;
        err_s      = 1'b0;
        ack_s      = 1'b0;
        case (state_r)
            IDLE, LOAD: begin
                if (xfer_s) begin
                    if (elem_idx_r == IW'(ELEMS - 1)) begin
                        if (in_last) begin
                            state_s = HOLD;
                        end else begin
                            err_s   = 1'b1;
                            state_s = IDLE;
                        end
                        elem_idx_s = '0;
                    end else if (in_last) begin
                        err_s      = 1'b1;
                        state_s    = IDLE;
                        elem_idx_s = '0;
                    end else begin
                        state_s    = LOAD;
                        elem_idx_s = elem_idx_r + IW'(1);
                    end
                end else begin
                    state_s = state_r;
                end
            end
            HOLD: begin
                if (mat_ack) begin
                    ack_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s    = IDLE;
                elem_idx_s = '0;
            end
        endcase
    end

    // State, handshake flags and handoff counter; flags are decoded from next state so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            elem_idx_r  <= '0;
            in_ready_r  <= 1'b1;
            mat_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            mat_cnt_r   <= 8'd0;
        end else begin
            state_r     <= state_s;
            elem_idx_r  <= elem_idx_s;
            in_ready_r  <= (state_s != HOLD);
            mat_valid_r <= (state_s == HOLD);
            frame_err_r <= err_s;
            if (ack_s) begin
                mat_cnt_r <= mat_cnt_r + 8'd1;
            end
        end
    end

    // Element register file; slots keep old contents until rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_data_r <= '0;
        end else if (xfer_s) begin
            mat_data_r[elem_idx_r*DATA_W +: DATA_W] <= in_data;
        end
    end

`ifdef MATRIX_LOADER_PIVOT_CHECK_EN
    logic [DATA_W-1:0] elem0_s;
    logic              pivot_zero_r;

    // Element 0 as it will be after this edge (covers the single-element matrix case).
    always_comb begin
        if (xfer_s && (elem_idx_r == IW'(0))) begin
            elem0_s = in_data;
        end else begin
            elem0_s = mat_data_r[DATA_W-1:0];
        end
    end

    // Pivot flag captured on HOLD entry and dropped when HOLD is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pivot_zero_r <= 1'b0;
        end else if ((state_r != HOLD) && (state_s == HOLD)) begin
            pivot_zero_r <= (elem0_s == '0);
        end else if (state_s != HOLD) begin
            pivot_zero_r <= 1'b0;
        end
    end

    assign pivot_zero = pivot_zero_r;
`else
    assign pivot_zero = 1'b0;
`endif

    assign in_ready  = in_ready_r;
    assign mat_valid = mat_valid_r;
    assign frame_err = frame_err_r;
    assign mat_cnt   = mat_cnt_r;
    assign mat_data  = mat_data_r;

endmodule
